handshake_ofifo_1: RTL and testbench

- Opaque elastic FIFO buffer placed directly downstream of a handshake constant.
- Decouples the constant's combinational valid/ready path (ctrl_ready = outs_ready) from the consumer, breaking the ready path and the data/valid path.
- Stores up to SLOTS tokens of DATA_WIDTH bits.
- Minimum token latency is one cycle; there is no combinational bypass.

---
 rtl/handshake_ofifo_1_if.sv | 28 ++
 rtl/handshake_ofifo_1.sv | 69 ++++++
 tb/tb_handshake_ofifo_1.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/handshake_ofifo_1_if.sv
`default_nettype none
// ============================================================================
// Module   : handshake_ofifo_1_if
// Brief    : Valid/ready token bus through the opaque output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface handshake_ofifo_1_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  // The FIFO itself sits on the slave side; producer/consumer drive master.
  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );
endinterface
`default_nettype wire

// File: rtl/handshake_ofifo_1.sv
`default_nettype none
// ============================================================================
// Module   : handshake_ofifo_1
// Brief    : Opaque elastic FIFO; all outputs come from registered state only.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_ofifo_1 #(
  parameter int DATA_WIDTH = 32,
  parameter int SLOTS      = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  handshake_ofifo_1_if.slave bus
);

  localparam int c_PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int c_CNT_W = $clog2(SLOTS + 1);
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(SLOTS - 1);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(SLOTS);

  logic [DATA_WIDTH-1:0] r_mem [SLOTS];
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_CNT_W-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  // Outputs are gated by rst so nothing is offered or accepted while in reset.
  assign bus.ins_ready  = rst & ~w_full;
  assign bus.outs_valid = rst & ~w_empty;
  assign bus.outs       = (rst && !w_empty) ? r_mem[r_head] : '0;

  assign w_push = bus.ins_valid  & bus.ins_ready;
  assign w_pop  = bus.outs_valid & bus.outs_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= bus.ins;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= (r_tail == c_LAST) ? '0 : r_tail + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= (r_head == c_LAST) ? '0 : r_head + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_handshake_ofifo_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_ofifo_1
// Brief    : Scoreboard bench for handshake_ofifo_1 at SLOTS = 2, 3 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_ofifo_1;

  logic clk;
  logic rst2, rst3, rst4;

  int vectors     = 0;
  int miscompares = 0;
  int pops3       = 0;

  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [31:0] q4[$];

  handshake_ofifo_1_if #(.DATA_WIDTH(32)) b2 ();
  handshake_ofifo_1_if #(.DATA_WIDTH(32)) b3 ();
  handshake_ofifo_1_if #(.DATA_WIDTH(32)) b4 ();

  handshake_ofifo_1 #(.DATA_WIDTH(32), .SLOTS(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(b2.slave));
  handshake_ofifo_1 #(.DATA_WIDTH(32), .SLOTS(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(b3.slave));
  handshake_ofifo_1 #(.DATA_WIDTH(32), .SLOTS(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the expected token whenever a DUT hands one over.
  always @(negedge clk) begin
    if (rst2 && b2.outs_valid && b2.outs_ready) begin
      if (q2.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL mon2_unexpected: got %0h expected none", b2.outs);
      end else chk("mon2_data", b2.outs, q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst3 && b3.outs_valid && b3.outs_ready) begin
      pops3++;
      if (q3.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL mon3_unexpected: got %0h expected none", b3.outs);
      end else chk("mon3_data", b3.outs, q3.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst4 && b4.outs_valid && b4.outs_ready) begin
      if (q4.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL mon4_unexpected: got %0h expected none", b4.outs);
      end else chk("mon4_data", b4.outs, q4.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pat;
    int          sent;
    int          cyc;
    logic        acc;

    rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    b2.ins = 32'h1; b2.ins_valid = 1'b1; b2.outs_ready = 1'b1;
    b3.ins = '0;    b3.ins_valid = 1'b0; b3.outs_ready = 1'b0;
    b4.ins = '0;    b4.ins_valid = 1'b0; b4.outs_ready = 1'b0;

    // Reset held with a pending token: nothing accepted, nothing offered.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ins_ready",  {31'd0, b2.ins_ready},  32'd0);
      chk("rst_outs_valid", {31'd0, b2.outs_valid}, 32'd0);
      chk("rst_outs",       b2.outs,                32'd0);
    end
    tick();
    b2.ins_valid = 1'b0;
    rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    @(negedge clk);
    chk("rel_ins_ready",  {31'd0, b2.ins_ready},  32'd1);
    chk("rel_outs_valid", {31'd0, b2.outs_valid}, 32'd0);

    // Latency: no bypass in the push cycle, visible the cycle after.
    b2.ins = 32'h1; b2.ins_valid = 1'b1; b2.outs_ready = 1'b1;
    q2.push_back(32'h1);
    #1;
    chk("lat_same_cycle_valid", {31'd0, b2.outs_valid}, 32'd0);
    tick();
    b2.ins_valid = 1'b0;
    @(negedge clk);
    chk("lat_next_valid", {31'd0, b2.outs_valid}, 32'd1);
    chk("lat_next_outs",  b2.outs,                32'h1);
    tick();

    // Fill to full, then pop while a new token waits.
    b2.outs_ready = 1'b0;
    b2.ins = 32'hA; b2.ins_valid = 1'b1;
    q2.push_back(32'hA); q2.push_back(32'hB); q2.push_back(32'hC);
    tick();
    b2.ins = 32'hB;
    tick();
    b2.ins = 32'hC; b2.outs_ready = 1'b1;
    @(negedge clk);
    chk("full_ins_ready", {31'd0, b2.ins_ready}, 32'd0);
    chk("full_head",      b2.outs,               32'hA);
    tick();
    @(negedge clk);
    chk("after_pop_ins_ready", {31'd0, b2.ins_ready}, 32'd1);
    chk("after_pop_head",      b2.outs,               32'hB);
    tick();
    b2.ins_valid = 1'b0;
    @(negedge clk);
    chk("c_head", b2.outs, 32'hC);
    tick();
    @(negedge clk);
    chk("drained_valid", {31'd0, b2.outs_valid}, 32'd0);

    // Throughput: one token per cycle once the first one is through.
    for (int i = 0; i < 20; i++) begin
      b2.ins = 32'h100 + i; b2.ins_valid = 1'b1;
      q2.push_back(32'h100 + i);
      tick();
      @(negedge clk);
      chk("tput_valid",     {31'd0, b2.outs_valid}, 32'd1);
      chk("tput_ins_ready", {31'd0, b2.ins_ready},  32'd1);
    end
    b2.ins_valid = 1'b0;
    tick();
    tick();
    chk("tput_q2_empty", q2.size(), 32'd0);

    // Wrap-around on SLOTS=3 with a fixed stall pattern on the consumer.
    pat  = 32'hB5C3_9A6D;
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || q3.size() != 0) && cyc < 200) begin
      b3.outs_ready = pat[cyc % 32] | (cyc >= 64);
      if (sent < 10) begin
        b3.ins = sent; b3.ins_valid = 1'b1;
      end else begin
        b3.ins_valid = 1'b0;
      end
      #1;
      acc = b3.ins_valid & b3.ins_ready;
      if (acc) q3.push_back(sent);
      tick();
      if (acc) sent++;
      cyc++;
    end
    b3.ins_valid = 1'b0;
    if (cyc >= 200) begin
      vectors++; miscompares++;
      $display("FAIL wrap_timeout: got %0d sent expected 10", sent);
    end
    tick();
    chk("wrap_pops", pops3, 32'd10);

    // Mid-operation reset on SLOTS=4 discards stored tokens.
    b4.outs_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      b4.ins = i; b4.ins_valid = 1'b1;
      tick();
    end
    b4.ins_valid = 1'b0;
    rst4 = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, b4.outs_valid}, 32'd0);
    chk("midrst_outs",  b4.outs,                32'd0);
    tick();
    rst4 = 1'b1;
    @(negedge clk);
    chk("postrst_valid", {31'd0, b4.outs_valid}, 32'd0);
    chk("postrst_ready", {31'd0, b4.ins_ready},  32'd1);
    b4.ins = 32'h5; b4.ins_valid = 1'b1; b4.outs_ready = 1'b1;
    q4.push_back(32'h5);
    tick();
    b4.ins_valid = 1'b0;
    @(negedge clk);
    chk("postrst_first", b4.outs, 32'h5);
    tick();
    tick();

    chk("end_q2_empty", q2.size(), 32'd0);
    chk("end_q3_empty", q3.size(), 32'd0);
    chk("end_q4_empty", q4.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
